fifo_to_axi4m_overlap: RTL and testbench
========================================

FIFO_TO_AXI4M_OVERLAP -- requirements
Module: fifo_to_axi4m_overlap

Interface
REQ-001 SHALL have parameter C_M_AXI_ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width; this revision supports 32 only.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  clock; reset_n  in  1  async active-low reset.
REQ-005 SHALL have these control ports: kick  in  1  start pulse; busy  out  1  transfer active; write_num  in  32  words to write; write_addr  in  32  byte start address; error  out  1  sticky non-OKAY BRESP seen.
REQ-006 SHALL have these FIFO ports (first-word-fall-through): buf_din  in  DATA  head word; buf_valid  in  1  FIFO not empty; buf_re  out  1  pop head.
REQ-007 SHALL have the AXI write-address channel: m_axi_awid/awaddr/awlen(8)/awsize(3)/awburst(2)/awlock(1)/awcache(4)/awprot(3)/awvalid  out; m_axi_awready  in.
REQ-008 SHALL have the AXI write-data channel: m_axi_wdata(DATA)/wstrb(DATA/8)/wlast/wvalid  out; m_axi_wready  in.
REQ-009 SHALL have the AXI write-response channel: m_axi_bid(ID)/bresp(2)/bvalid  in; m_axi_bready  out.

Function
REQ-010 SHALL drive constants: awid=0, awsize=3'b010, awburst=INCR (2'b01), awlock=0, awcache=4'b0010, awprot=0, wstrb=all ones.
REQ-011 SHALL implement states s_idle, s_kick, s_addrcalc, s_addrissue, s_datawrite, s_respwait.
REQ-012 SHALL move s_idle->s_kick when kick=1; kick SHALL be ignored in every other state.
REQ-013 SHALL, in s_kick, latch write_num/write_addr into remaining count and next address, then go to s_addrcalc, or to s_respwait when write_num=0.
REQ-014 SHALL, in s_addrcalc, set len=min(remaining,64), awlen=len-1, awaddr=next address, remaining-=len, next address+=4*len, outstanding-burst count+=1.
REQ-015 SHALL assert awvalid only in s_addrissue, holding awaddr/awlen stable until awready=1, then enter s_datawrite.
REQ-016 SHALL, in s_datawrite, drive wvalid=buf_valid, wdata=buf_din, buf_re=wvalid&wready; a beat SHALL count only when wvalid&wready.
REQ-017 SHALL assert wlast when the beat counter equals awlen; the wlast handshake SHALL go to s_addrcalc if remaining>0, else s_respwait.
REQ-018 SHALL drive bready=1 in every state except s_idle; each bvalid&bready SHALL increment the response count.
REQ-019 SHALL leave s_respwait for s_idle once response count equals outstanding-burst count; busy=1 in every state except s_idle.
REQ-020 SHALL set error on bvalid&bready with bresp!=2'b00 and clear it only on kick accepted in s_idle or reset.
REQ-021 SHALL keep burst and response counters 16-bit, clearing both in s_idle; callers SHALL bound write_num to 65535*64 words.
REQ-022 SHALL require write_addr to be 256-byte aligned so no burst crosses a 4 KB boundary; misaligned addresses are unsupported.
REQ-023 SHALL stall without dropping or duplicating data when buf_valid=0 mid-burst: wvalid low, counter held.

Reset
REQ-024 SHALL, on reset_n=0 at any time including mid-burst, asynchronously return to s_idle with awvalid=wvalid=wlast=buf_re=bready=busy=error=0, awaddr=0, awlen=0, all counters 0.
REQ-025 SHALL leave reset cleanly on the first clk edge after reset_n rises; abandoned AXI bursts are the system's responsibility.

Structure
REQ-026 SHALL take MAX_BURST_LENGTH=64, INCR/OKAY encodings and awcache value from shared package axi4m_pkg, also used by the read-side master.
REQ-027 SHALL place the min/len/next-address computation in sub-module axi4m_burst_calc, reusable by the read-side master.

Verification
REQ-028 SHALL cover write_num=4, addr=0x1000, FIFO preloaded, awready/wready=1 -> one burst awaddr=0x1000 awlen=3, 4 beats, wlast on beat 4, busy drops after one OKAY.
REQ-029 SHALL cover write_num=130, addr=0x0 -> bursts awaddr 0x0/0x100/0x200, awlen 63/63/1, 130 pops, idle after 3 responses.
REQ-030 SHALL cover write_num=8 with buf_valid toggling every cycle and wready low 2 of 3 cycles -> data order preserved, exactly 8 pops, wlast on 8th handshake.
REQ-031 SHALL cover write_num=0 -> no awvalid/wvalid, busy high for exactly 3 cycles (s_kick, s_respwait, s_idle exit).
REQ-032 SHALL cover bresp=2'b10 on burst 2 of 3 -> error set and held after idle, cleared by the next accepted kick.
REQ-033 SHALL cover reset_n low during beat 10 of a 64-beat burst -> all outputs 0 immediately, next kick runs a normal transfer.

Source files
------------

// File: rtl/axi4m_pkg.sv
// Shared AXI4 master definitions for the FIFO-to-AXI write master and its read-side sibling.
package axi4m_pkg;

    // Longest INCR burst either master issues, in beats
    localparam int unsigned MAX_BURST_LENGTH = 64;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_AXCACHE    = 4'b0010;  // normal non-cacheable, non-bufferable
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;   // 32-bit beats

    // Write-master sequencing states
    typedef enum logic [2:0] {
        s_idle,
        s_kick,
        s_addrcalc,
        s_addrissue,
        s_datawrite,
        s_respwait
    } wr_state_e;

endpackage

// File: rtl/axi4m_burst_calc.sv
// Splits a transfer into bursts: picks the next burst length, its AxLEN encoding,
// and the words/address left over once that burst has been issued.
module axi4m_burst_calc
    import axi4m_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [31:0]           remaining_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [7:0]            axlen_o,
    output logic [31:0]           remaining_o,
    output logic [ADDR_WIDTH-1:0] addr_next_o
);

    logic [7:0] len;

    // Burst length is the smaller of the words left and the maximum burst size
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path; the
        // defaults up front guarantee that and keep synthesis from inferring latches.
        len         = remaining_i[7:0];
        axlen_o     = '0;
        remaining_o = remaining_i;
        addr_next_o = addr_i;
        if (remaining_i > 32'(MAX_BURST_LENGTH)) begin
            len = 8'(MAX_BURST_LENGTH);
        end
        axlen_o     = len - 8'd1;
        remaining_o = remaining_i - 32'(len);
        addr_next_o = addr_i + ADDR_WIDTH'({len, 2'b00});
    end

endmodule

// File: rtl/fifo_to_axi4m_overlap.sv
// Drains a first-word-fall-through FIFO into memory as a series of AXI4 INCR write
// bursts. Write responses are collected in the background while later bursts issue,
// and the transfer completes once every issued burst has been answered.
module fifo_to_axi4m_overlap
    import axi4m_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    // Control
    input  logic                            kick,
    output logic                            busy,
    input  logic [31:0]                     write_num,
    input  logic [31:0]                     write_addr,
    output logic                            error,
    // FIFO read side
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   buf_din,
    input  logic                            buf_valid,
    output logic                            buf_re,
    // AXI write address channel
    output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awlock,
    output logic [3:0]                      m_axi_awcache,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    // AXI write data channel
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    // AXI write response channel
    input  logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    wr_state_e state_q, state_d;

    logic [31:0]                   remaining_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] next_addr_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0]                    awlen_q;
    logic [7:0]                    beat_q;
    logic [15:0]                   burst_cnt_q;
    logic [15:0]                   resp_cnt_q;
    logic                          error_q;
    logic                          busy_q;

    logic [7:0]                    calc_axlen;
    logic [31:0]                   calc_remaining;
    logic [C_M_AXI_ADDR_WIDTH-1:0] calc_addr_next;

    logic w_hs;
    logic b_hs;

    // Responses carry no ID information this master needs (single ID, in-order)
    logic unused_bid;
    assign unused_bid = ^m_axi_bid;

    assign w_hs = m_axi_wvalid & m_axi_wready;
    assign b_hs = m_axi_bvalid & m_axi_bready;

    axi4m_burst_calc #(
        .ADDR_WIDTH (C_M_AXI_ADDR_WIDTH)
    ) u_burst_calc (
        .remaining_i (remaining_q),
        .addr_i      (next_addr_q),
        .axlen_o     (calc_axlen),
        .remaining_o (calc_remaining),
        .addr_next_o (calc_addr_next)
    );

    // Fixed AXI attributes: single ID, 4-byte INCR bursts, every byte lane written
    assign m_axi_awid    = '0;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_AXCACHE;
    assign m_axi_awprot  = '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_wdata   = buf_din;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign busy          = busy_q;
    assign error         = error_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state is always updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of block ordering.
        if (!reset_n) begin
            state_q <= s_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kick is only looked at while idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            s_idle:      if (kick) state_d = s_kick;
            s_kick:      state_d = (write_num == 32'd0) ? s_respwait : s_addrcalc;
            s_addrcalc:  state_d = s_addrissue;
            s_addrissue: if (m_axi_awready) state_d = s_datawrite;
            s_datawrite: begin
                if (w_hs && m_axi_wlast) begin
                    state_d = (remaining_q != 32'd0) ? s_addrcalc : s_respwait;
                end
            end
            s_respwait:  if (resp_cnt_q == burst_cnt_q) state_d = s_idle;
            default:     state_d = s_idle;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        m_axi_awvalid = (state_q == s_addrissue);
        m_axi_wvalid  = (state_q == s_datawrite) && buf_valid;
        m_axi_wlast   = (state_q == s_datawrite) && (beat_q == awlen_q);
        buf_re        = m_axi_wvalid && m_axi_wready;
        m_axi_bready  = (state_q != s_idle);
    end

    // Transfer bookkeeping: words left, next burst address and the AW beat on offer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining_q <= '0;
            next_addr_q <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
        end else begin
            case (state_q)
                s_kick: begin
                    remaining_q <= write_num;
                    next_addr_q <= C_M_AXI_ADDR_WIDTH'(write_addr);
                end
                s_addrcalc: begin
                    awaddr_q    <= next_addr_q;
                    awlen_q     <= calc_axlen;
                    remaining_q <= calc_remaining;
                    next_addr_q <= calc_addr_next;
                end
                default: ;
            endcase
        end
    end

    // Beat position inside the current burst; only accepted beats advance it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
        end else if (state_q == s_addrcalc) begin
            beat_q <= '0;
        end else if ((state_q == s_datawrite) && w_hs) begin
            beat_q <= beat_q + 8'd1;
        end
    end

    // Issued-burst and received-response counters, cleared between transfers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt_q <= '0;
            resp_cnt_q  <= '0;
        end else if (state_q == s_idle) begin
            burst_cnt_q <= '0;
            resp_cnt_q  <= '0;
        end else begin
            if (state_q == s_addrcalc) burst_cnt_q <= burst_cnt_q + 16'd1;
            if (b_hs)                  resp_cnt_q  <= resp_cnt_q + 16'd1;
        end
    end

    // Sticky error on any non-OKAY response, cleared when the next transfer is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_q <= 1'b0;
        end else if ((state_q == s_idle) && kick) begin
            error_q <= 1'b0;
        end else if (b_hs && (m_axi_bresp != AXI_RESP_OKAY)) begin
            error_q <= 1'b1;
        end
    end

    // Busy rises as a kick is accepted and falls one cycle after returning to idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_d != s_idle) || (state_q != s_idle);
        end
    end

endmodule

// File: tb/tb_fifo_to_axi4m_overlap.sv
// Randomised bench for fifo_to_axi4m_overlap: a FWFT FIFO model plus AXI slave
// responders, checked against a burst/data/response model built from the
// transfer parameters.
module tb_fifo_to_axi4m_overlap;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic            clk;
    logic            reset_n;
    logic            kick;
    logic            busy;
    logic [31:0]     write_num;
    logic [31:0]     write_addr;
    logic            error;
    logic [DW-1:0]   buf_din;
    logic            buf_valid;
    logic            buf_re;
    logic [IDW-1:0]  m_axi_awid;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awlock;
    logic [3:0]      m_axi_awcache;
    logic [2:0]      m_axi_awprot;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [IDW-1:0]  m_axi_bid;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;

    fifo_to_axi4m_overlap #(
        .C_M_AXI_ID_WIDTH   (IDW),
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .kick          (kick),
        .busy          (busy),
        .write_num     (write_num),
        .write_addr    (write_addr),
        .error         (error),
        .buf_din       (buf_din),
        .buf_valid     (buf_valid),
        .buf_re        (buf_re),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awlock  (m_axi_awlock),
        .m_axi_awcache (m_axi_awcache),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bid     (m_axi_bid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs
    int aw_pct   = 100;
    int w_pct    = 100;
    int fifo_pct = 100;
    int b_pct    = 60;
    bit w_mode    = 1'b0;   // 1: wready high one cycle in three
    bit fifo_mode = 1'b0;   // 1: buf_valid gate toggles every cycle
    bit fifo_gate = 1'b0;
    int cyc       = 0;

    // Model state
    logic [31:0] fifo[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_aw_addr[$];
    int          exp_aw_len[$];
    int          exp_wlens[$];
    logic [1:0]  bq[$];
    int          exp_nb;
    int          cur_beat;
    int          burst_idx;
    int          err_idx;
    bit          err_model;
    bit          pop_pend;
    bit          b_hs_pend;

    // Observations
    logic [31:0] obs_aw_addr[$];
    int          obs_aw_len[$];
    int          beats_seen;
    int          pops;
    int          resps;
    int          busy_cyc;
    int          first_wlast_beat;
    bit          aw_hold;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave/FIFO driver: updates all DUT inputs just after each rising edge
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_bid     = '0;
        buf_valid     = 1'b0;
        buf_din       = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pop_pend) begin
                if (fifo.size() > 0) fifo.delete(0);
                pop_pend = 1'b0;
            end
            if (b_hs_pend) begin
                b_hs_pend    = 1'b0;
                m_axi_bvalid = 1'b0;
                if (bq.size() > 0) bq.delete(0);
            end
            if (!m_axi_bvalid && (bq.size() > 0) && ($urandom_range(0, 99) < b_pct)) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = bq[0];
            end
            m_axi_awready = ($urandom_range(0, 99) < aw_pct);
            m_axi_wready  = w_mode ? ((cyc % 3) == 0) : ($urandom_range(0, 99) < w_pct);
            fifo_gate     = fifo_mode ? ~fifo_gate : ($urandom_range(0, 99) < fifo_pct);
            buf_valid     = (fifo.size() > 0) && fifo_gate;
            buf_din       = (fifo.size() > 0) ? fifo[0] : 32'h0;
        end
    end

    // Compare process: checks every handshake against the model at mid-cycle
    initial begin
        bit last;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                aw_hold = 1'b0;
            end else begin
                if (busy) busy_cyc++;
                check("buf_re", buf_re, m_axi_wvalid & m_axi_wready);
                if (m_axi_wvalid) check("wvalid_without_buf_valid", buf_valid, 1'b1);
                if (buf_re) begin
                    pops++;
                    pop_pend = 1'b1;
                end
                if (aw_hold) begin
                    check("awvalid_dropped", m_axi_awvalid, 1'b1);
                    check("awaddr_unstable", m_axi_awaddr, hold_addr);
                    check("awlen_unstable", m_axi_awlen, hold_len);
                end
                if (exp_aw_addr.size() == 0) begin
                    check("awvalid_unexpected", m_axi_awvalid, 1'b0);
                end else if (m_axi_awvalid && m_axi_awready) begin
                    check("awaddr", m_axi_awaddr, exp_aw_addr[0]);
                    check("awlen", m_axi_awlen, exp_aw_len[0]);
                    check("awsize", m_axi_awsize, 3'b010);
                    check("awburst", m_axi_awburst, 2'b01);
                    check("awcache", m_axi_awcache, 4'b0010);
                    check("aw_id_lock_prot", {m_axi_awid, m_axi_awlock, m_axi_awprot}, 0);
                    obs_aw_addr.push_back(m_axi_awaddr);
                    obs_aw_len.push_back(int'(m_axi_awlen));
                    exp_aw_addr.delete(0);
                    exp_aw_len.delete(0);
                end
                aw_hold   = m_axi_awvalid && !m_axi_awready;
                hold_addr = m_axi_awaddr;
                hold_len  = m_axi_awlen;
                if (exp_wlens.size() == 0) begin
                    check("wvalid_unexpected", m_axi_wvalid, 1'b0);
                end else if (m_axi_wvalid && m_axi_wready) begin
                    beats_seen++;
                    if (exp_data.size() > 0) begin
                        check("wdata", m_axi_wdata, exp_data[0]);
                        exp_data.delete(0);
                    end
                    check("wstrb", m_axi_wstrb, 4'hF);
                    last = (cur_beat == exp_wlens[0] - 1);
                    check("wlast", m_axi_wlast, last);
                    if (m_axi_wlast && first_wlast_beat < 0) first_wlast_beat = beats_seen;
                    if (last) begin
                        cur_beat = 0;
                        exp_wlens.delete(0);
                        bq.push_back((burst_idx == err_idx) ? 2'b10 : 2'b00);
                        burst_idx++;
                    end else begin
                        cur_beat++;
                    end
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    resps++;
                    b_hs_pend = 1'b1;
                    if (m_axi_bresp != 2'b00) err_model = 1'b1;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected below 900000", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_knobs(input int a, input int w, input int f, input bit wm, input bit fm);
        aw_pct    = a;
        w_pct     = w;
        fifo_pct  = f;
        w_mode    = wm;
        fifo_mode = fm;
    endtask

    // Builds the expected burst list and data, preloads the FIFO and pulses kick
    task automatic start_transfer(input int num, input logic [31:0] addr, input int e_idx);
        int rem;
        int l;
        logic [31:0] a;
        logic [31:0] w;
        err_idx   = e_idx;
        burst_idx = 0;
        cur_beat  = 0;
        exp_nb    = 0;
        pops = 0; resps = 0; beats_seen = 0; busy_cyc = 0;
        first_wlast_beat = -1;
        obs_aw_addr.delete();
        obs_aw_len.delete();
        rem = num;
        a   = addr;
        while (rem > 0) begin
            l = (rem > 64) ? 64 : rem;
            exp_aw_addr.push_back(a);
            exp_aw_len.push_back(l - 1);
            exp_wlens.push_back(l);
            a   = a + 32'(4 * l);
            rem = rem - l;
            exp_nb++;
        end
        for (int i = 0; i < num; i++) begin
            w = $urandom;
            fifo.push_back(w);
            exp_data.push_back(w);
        end
        write_num  = num;
        write_addr = addr;
        @(posedge clk); #2;
        kick = 1'b1;
        @(posedge clk); #2;
        kick = 1'b0;
        err_model = 1'b0;
        check("busy_after_kick", busy, 1'b1);
        check("error_after_kick", error, err_model);
    endtask

    task automatic finish_transfer(input int num, input bit poke);
        int t;
        t = 0;
        while (busy && t < 20000) begin
            @(negedge clk); #1;
            t++;
            if (poke) kick = (t == 1);
        end
        kick = 1'b0;
        check("busy_drop_timeout", busy, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("pop_count", pops, num);
        check("resp_count", resps, exp_nb);
        check("data_left", exp_data.size(), 0);
        check("aw_left", exp_aw_addr.size() + exp_wlens.size(), 0);
        check("error_at_end", error, err_model);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, buf_re, m_axi_bready}, 0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_awaddr"}, m_axi_awaddr, 0);
        check({tag, "_awlen"}, m_axi_awlen, 0);
    endtask

    task automatic flush_model();
        fifo.delete(); exp_data.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
        exp_wlens.delete(); bq.delete();
        pop_pend = 1'b0; b_hs_pend = 1'b0; m_axi_bvalid = 1'b0;
        cur_beat = 0; err_model = 1'b0;
    endtask

    initial begin
        int t;
        int n;
        int e;
        logic [31:0] a;
        reset_n = 1'b0; kick = 1'b0; write_num = '0; write_addr = '0;
        err_idx = -1; exp_nb = 0; err_model = 1'b0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Single short burst, everything ready
        set_knobs(100, 100, 100, 1'b0, 1'b0);
        start_transfer(4, 32'h1000, -1);
        finish_transfer(4, 1'b0);
        check("t1_bursts", obs_aw_addr.size(), 1);
        if (obs_aw_addr.size() == 1) begin
            check("t1_awaddr", obs_aw_addr[0], 32'h1000);
            check("t1_awlen", obs_aw_len[0], 3);
        end
        check("t1_wlast_beat", first_wlast_beat, 4);
        check("t1_resps", resps, 1);

        // Three bursts: 64 + 64 + 2
        start_transfer(130, 32'h0, -1);
        finish_transfer(130, 1'b0);
        check("t2_bursts", obs_aw_addr.size(), 3);
        if (obs_aw_addr.size() == 3) begin
            check("t2_addr0", obs_aw_addr[0], 32'h0);
            check("t2_addr1", obs_aw_addr[1], 32'h100);
            check("t2_addr2", obs_aw_addr[2], 32'h200);
            check("t2_len0", obs_aw_len[0], 63);
            check("t2_len1", obs_aw_len[1], 63);
            check("t2_len2", obs_aw_len[2], 1);
        end
        check("t2_pops", pops, 130);
        check("t2_resps", resps, 3);

        // FIFO toggling and sparse wready
        set_knobs(100, 100, 100, 1'b1, 1'b1);
        start_transfer(8, 32'h800, -1);
        finish_transfer(8, 1'b0);
        check("t3_pops", pops, 8);
        check("t3_wlast_beat", first_wlast_beat, 8);

        // Empty transfer
        set_knobs(100, 100, 100, 1'b0, 1'b0);
        start_transfer(0, 32'h500, -1);
        finish_transfer(0, 1'b0);
        check("t4_busy_cycles", busy_cyc, 3);
        check("t4_bursts", obs_aw_addr.size(), 0);

        // SLVERR on the second of three bursts, then cleared by the next kick
        set_knobs(70, 70, 80, 1'b0, 1'b0);
        start_transfer(130, 32'h4000, 1);
        finish_transfer(130, 1'b0);
        check("t5_error_held", error, 1'b1);
        start_transfer(5, 32'h4400, -1);
        check("t6_error_cleared", error, 1'b0);
        finish_transfer(5, 1'b0);

        // Randomised transfers, with a stray kick mid-transfer
        for (int k = 0; k < 6; k++) begin
            set_knobs($urandom_range(30, 100), $urandom_range(30, 100),
                      $urandom_range(30, 100), 1'b0, 1'b0);
            n = $urandom_range(1, 200);
            a = 32'($urandom_range(0, 16'hFFFF)) << 8;
            e = int'($urandom_range(0, 3)) - 1;
            start_transfer(n, a, e);
            finish_transfer(n, 1'b1);
        end

        // Reset during beat 10 of a 64-beat burst
        set_knobs(100, 100, 100, 1'b0, 1'b0);
        start_transfer(64, 32'h2000, -1);
        t = 0;
        while (beats_seen < 9 && t < 1000) begin
            @(negedge clk); #1;
            t++;
        end
        check("t7_beats_before_reset", beats_seen, 9);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #3;
        flush_model();
        @(negedge clk);
        reset_n = 1'b1;
        set_knobs(80, 80, 80, 1'b0, 1'b0);
        start_transfer(20, 32'h3000, -1);
        finish_transfer(20, 1'b0);
        check("t8_bursts", obs_aw_addr.size(), 1);
        check("t8_pops", pops, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
